// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage in front of an asynchronous instruction ROM.
// Drives rom_address from fetch_pc, captures rom_rdata on the same edge and
// buffers {pc, inst} pairs in a DEPTH-entry FIFO that feeds decode over a
// valid/ready handshake. A redirect flushes the queue and restarts fetch.
// Fetch halts when the PC leaves the ROM range.
// Optional: define FETCH_MISALIGN_CHECK_EN to add a sticky fetch_misalign
// output and halt on a redirect to a non word-aligned address.
module inst_fetch_queue #(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 4,
  parameter int                 ROM_DEPTH = 2048,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0
) (
  input  logic             clock,
  input  logic             nreset,
  output logic [WIDTH-1:0] rom_address,
  input  logic [WIDTH-1:0] rom_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             halted
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic             fetch_misalign
`endif
);

  localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    FULL      = (AW+1)'(DEPTH);
  // one bit wider than the PC so the limit itself is representable
  localparam logic [WIDTH:0] ROM_LIMIT = (WIDTH+1)'(ROM_DEPTH) << 2;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
  } entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] fetch_pc;
  state_t           state, state_nxt;

  logic             push, pop;
  logic             pc_ok, rpc_ok, misalign;
  logic [WIDTH-1:0] rpc_al;

  // low two bits of a redirect target are always dropped
  assign rpc_al = {redirect_pc[WIDTH-1:2], 2'b00};
  assign pc_ok  = {1'b0, fetch_pc} < ROM_LIMIT;
  assign rpc_ok = {1'b0, rpc_al}   < ROM_LIMIT;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_lowbits;
  assign unused_lowbits = ^redirect_pc[1:0];
  assign misalign       = 1'b0;
`endif

  // the head is hidden during a redirect so nothing is consumed from a
  // queue that is about to be flushed
  assign inst_valid  = (count != '0) && !redirect;
  assign pop         = inst_valid && inst_ready;
  assign rom_address = fetch_pc;
  assign halted      = (state == HALT);
  assign inst        = (count != '0) ? mem[rd_ptr].inst : '0;
  assign inst_pc     = (count != '0) ? mem[rd_ptr].pc   : '0;

  // next state and push decision; redirect overrides everything
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    if (redirect) begin
      state_nxt = (rpc_ok && !misalign) ? FETCH : HALT;
    end else begin
      case (state)
        FETCH: begin
          // range is checked first so an out-of-range PC is never pushed
          if (!pc_ok) state_nxt = HALT;
          else        push      = (count != FULL) || pop;
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // state register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= FETCH;
    else         state <= state_nxt;
  end

  // fetch PC: load on redirect, step one word per push
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)       fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= rpc_al;
    else if (push)     fetch_pc <= fetch_pc + WIDTH'(4);
  end

  // queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage; contents are only observed while count != 0
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr].pc   <= fetch_pc;
      mem[wr_ptr].inst <= rom_rdata;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)       fetch_misalign <= 1'b0;
    else if (misalign) fetch_misalign <= 1'b1;
  end
`endif

endmodule
